// File: rtl/stream_normalizer.sv
// Stream normalizer: compacts sparse per-element keeps into dense output beats,
// carrying leftover elements across beats and never merging packets.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting input, residue + new elements merged into output
// TAIL  | input stalled, flushing leftover residue as the packet's last beat
module stream_normalizer #(
   parameter int ELEMENT_WIDTH = 8,
   parameter int NUM_ELEMENTS  = 8,
   parameter int ALLOW_SPARSE  = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_data,
   input  logic [NUM_ELEMENTS-1:0]               in_keep,
   input  logic                                  in_last,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] out_data,
   output logic [NUM_ELEMENTS-1:0]               out_keep,
   output logic                                  out_last,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int N  = NUM_ELEMENTS;
   localparam int EW = ELEMENT_WIDTH;
   localparam int CW = $clog2(N);
   localparam logic [CW:0] N_W = (CW+1)'(N);

   typedef enum logic {ACCUM, TAIL} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     r_q, r_d;
   logic [EW-1:0]     res_q [N-1];
   logic [EW-1:0]     res_d [N-1];
   logic [EW-1:0]     comb  [2*N];
   logic [CW:0]       k_cnt;
   logic [CW:0]       s_sum;
   logic [N-1:0]      keep_s;
   logic [N-1:0]      keep_r;
   logic [N*EW-1:0]   lo_data;
   logic              out_free;
   logic              accept;
   logic              load;
   logic [N-1:0]      ld_keep;
   logic              ld_last;

   assign out_free = !out_valid || out_ready;
   assign in_ready = !rst && (state_q == ACCUM) && out_free;
   assign accept   = in_valid && in_ready;

   // Residue occupies slots [0, R); new elements are packed directly after it.
   always_comb begin
      k_cnt = '0;
      for (int i = 0; i < 2*N; i++) comb[i] = '0;
      for (int i = 0; i < N-1; i++) begin
         if (CW'(i) < r_q) comb[i] = res_q[i];
      end
      for (int j = 0; j < N; j++) begin
         if (ALLOW_SPARSE != 0) begin
            if (in_keep[j]) begin
               comb[(CW+1)'(r_q) + k_cnt] = in_data[j*EW +: EW];
               k_cnt = k_cnt + (CW+1)'(1);
            end
         end else begin
            comb[(CW+1)'(r_q) + (CW+1)'(j)] = in_data[j*EW +: EW];
            k_cnt = k_cnt + (CW+1)'(in_keep[j]);
         end
      end
      s_sum = (CW+1)'(r_q) + k_cnt;
      for (int i = 0; i < N; i++) begin
         lo_data[i*EW +: EW] = comb[i];
         keep_s[i] = ((CW+1)'(i) < s_sum);
         keep_r[i] = (CW'(i) < r_q);
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      for (int i = 0; i < N-1; i++) res_d[i] = res_q[i];
      load    = 1'b0;
      ld_keep = '0;
      ld_last = 1'b0;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               if (!in_last) begin
                  if (s_sum < N_W) begin
                     r_d = s_sum[CW-1:0];
                     for (int i = 0; i < N-1; i++) res_d[i] = comb[i];
                  end else begin
                     load    = 1'b1;
                     ld_keep = '1;
                     r_d     = CW'(s_sum - N_W);
                     for (int i = 0; i < N-1; i++) res_d[i] = comb[N+i];
                  end
               end else if (s_sum <= N_W) begin
                  load    = 1'b1;
                  ld_keep = keep_s;
                  ld_last = 1'b1;
                  r_d     = '0;
               end else begin
                  load    = 1'b1;
                  ld_keep = '1;
                  r_d     = CW'(s_sum - N_W);
                  for (int i = 0; i < N-1; i++) res_d[i] = comb[N+i];
                  state_d = TAIL;
               end
            end
         end
         TAIL: begin
            if (out_free) begin
               load    = 1'b1;
               ld_keep = keep_r;
               ld_last = 1'b1;
               r_d     = '0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCUM;
         r_q       <= '0;
         out_valid <= 1'b0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         if (load) begin
            out_valid <= 1'b1;
            out_keep  <= ld_keep;
            out_last  <= ld_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Payload storage carries no reset; R and out_keep qualify it.
   always_ff @(posedge clk) begin
      if (load) out_data <= lo_data;
      for (int i = 0; i < N-1; i++) res_q[i] <= res_d[i];
   end

endmodule

// File: tb/tb_stream_normalizer.sv
// Self-checking bench for stream_normalizer (N=4, 8-bit elements, sparse on):
// directed scenarios plus randomized packets against a queue-based model.
module tb_stream_normalizer;

   localparam int EW = 8;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   in_data;
   logic [3:0]    in_keep;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   out_data;
   logic [3:0]    out_keep;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       obs_q[$];
   beat_t       mon_b;
   logic [7:0]  pend[$];
   int          total = 0;
   int          bad   = 0;
   bit          rand_rdy = 1'b0;

   always #5 clk = ~clk;

   stream_normalizer #(.ELEMENT_WIDTH(EW), .NUM_ELEMENTS(N), .ALLOW_SPARSE(1)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         mon_b.data = out_data;
         mon_b.keep = out_keep;
         mon_b.last = out_last;
         obs_q.push_back(mon_b);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] kmask(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   // Reference: packet elements flow through a FIFO; full groups of N leave as
   // beats, and the packet end flushes whatever remains as the last beat.
   function automatic void model_emit(input int n, input logic l);
      beat_t b;
      b.data = '0;
      for (int i = 0; i < n; i++) b.data[i*8 +: 8] = pend.pop_front();
      b.keep = 4'((1 << n) - 1);
      b.last = l;
      exp_q.push_back(b);
   endfunction

   function automatic void model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      for (int i = 0; i < 4; i++) if (k[i]) pend.push_back(d[i*8 +: 8]);
      if (!l) begin
         while (pend.size() >= N) model_emit(N, 1'b0);
      end else begin
         while (pend.size() > N) model_emit(N, 1'b0);
         model_emit(pend.size(), 1'b1);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 1000) begin
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
            $display("test done: total=%0d bad=%0d", total, bad + 1);
            $fatal(1, "handshake timeout");
         end
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) step();
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_keep, out_last} !== 7'b0) begin
         $display("FAIL reset_hold: got rdy/vld/keep/last=%b want 0000000",
                  {in_ready, out_valid, out_keep, out_last});
         bad++;
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_keep, out_last} !== 7'b1000000) begin
         $display("FAIL reset_release: got rdy/vld/keep/last=%b want 1000000",
                  {in_ready, out_valid, out_keep, out_last});
         bad++;
      end
      step();
   endtask

   task automatic test_dense();
      obs_q.delete();
      for (int i = 0; i < 4; i++)
         send_beat({16'h0, 8'(2*i+2), 8'(2*i+1)}, 4'b0011, i == 3);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 2) begin
         $display("FAIL dense_count: got %0d want 2", obs_q.size());
         bad++;
      end else begin
         total++;
         if ({obs_q[0].data, obs_q[0].keep, obs_q[0].last} !== {32'h04030201, 4'hf, 1'b0}) begin
            $display("FAIL dense_beat0: got %h/%h/%b want 04030201/f/0",
                     obs_q[0].data, obs_q[0].keep, obs_q[0].last);
            bad++;
         end
         total++;
         if ({obs_q[1].data, obs_q[1].keep, obs_q[1].last} !== {32'h08070605, 4'hf, 1'b1}) begin
            $display("FAIL dense_beat1: got %h/%h/%b want 08070605/f/1",
                     obs_q[1].data, obs_q[1].keep, obs_q[1].last);
            bad++;
         end
      end
   endtask

   task automatic test_tail();
      int lows;
      obs_q.delete();
      send_beat(32'h000C0B0A, 4'b0111, 1'b0);
      send_beat(32'h000F0E0D, 4'b0111, 1'b1);
      lows = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            total++;
            if ({out_valid, out_keep, out_last, out_data} !== {1'b1, 4'hf, 1'b0, 32'h0D0C0B0A}) begin
               $display("FAIL tail_first: got v%b k%h l%b d%h want v1 kf l0 d0d0c0b0a",
                        out_valid, out_keep, out_last, out_data);
               bad++;
            end
         end
         if (c == 1) begin
            total++;
            if ({out_valid, out_keep, out_last, out_data[15:0]} !== {1'b1, 4'h3, 1'b1, 16'h0F0E}) begin
               $display("FAIL tail_second: got v%b k%h l%b d%h want v1 k3 l1 d....0f0e",
                        out_valid, out_keep, out_last, out_data);
               bad++;
            end
         end
         if (!in_ready) lows++;
         step();
      end
      total++;
      if (lows !== 1) begin
         $display("FAIL tail_stall: in_ready low %0d cycles, want 1", lows);
         bad++;
      end
      total++;
      if (obs_q.size() !== 2) begin
         $display("FAIL tail_count: got %0d want 2", obs_q.size());
         bad++;
      end
   endtask

   task automatic test_backpressure();
      obs_q.delete();
      out_ready = 1'b0;
      in_data = 32'h44332211; in_keep = 4'hf; in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         $display("FAIL bp_first_ready: got %b want 1", in_ready);
         bad++;
      end
      step();
      in_data = 32'h88776655; in_last = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({out_valid, out_keep, out_last, out_data, in_ready} !== {1'b1, 4'hf, 1'b0, 32'h44332211, 1'b0}) begin
            $display("FAIL bp_hold%0d: got v%b k%h l%b d%h rdy%b want v1 kf l0 d44332211 rdy0",
                     c, out_valid, out_keep, out_last, out_data, in_ready);
            bad++;
         end
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      repeat (3) step();
      total++;
      if (obs_q.size() !== 2) begin
         $display("FAIL bp_count: got %0d want 2", obs_q.size());
         bad++;
      end else begin
         total++;
         if ({obs_q[0].data, obs_q[0].last, obs_q[1].data, obs_q[1].last} !==
             {32'h44332211, 1'b0, 32'h88776655, 1'b1}) begin
            $display("FAIL bp_order: got %h/%b %h/%b want 44332211/0 88776655/1",
                     obs_q[0].data, obs_q[0].last, obs_q[1].data, obs_q[1].last);
            bad++;
         end
      end
   endtask

   task automatic test_sparse();
      obs_q.delete();
      send_beat(32'hD4C3B2A1, 4'b1010, 1'b0);
      send_beat(32'h1807F6E5, 4'b1010, 1'b1);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 1) begin
         $display("FAIL sparse_count: got %0d want 1", obs_q.size());
         bad++;
      end else begin
         total++;
         if ({obs_q[0].data, obs_q[0].keep, obs_q[0].last} !== {32'h18F6D4B2, 4'hf, 1'b1}) begin
            $display("FAIL sparse_beat: got %h/%h/%b want 18f6d4b2/f/1",
                     obs_q[0].data, obs_q[0].keep, obs_q[0].last);
            bad++;
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_q.delete();
      in_valid = 1'b1; in_keep = 4'hf;
      for (int i = 0; i < 6; i++) begin
         in_data = {4{8'(8'h30 + i)}};
         in_last = (i == 5);
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin
            $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
            bad++;
         end
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      repeat (3) step();
      total++;
      if (obs_q.size() !== 6) begin
         $display("FAIL b2b_count: got %0d want 6", obs_q.size());
         bad++;
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if ({obs_q[i].data, obs_q[i].keep, obs_q[i].last} !== {{4{8'(8'h30 + i)}}, 4'hf, i == 5}) begin
               $display("FAIL b2b_beat%0d: got %h/%h/%b", i, obs_q[i].data, obs_q[i].keep, obs_q[i].last);
               bad++;
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_beat(32'h00131211, 4'b0111, 1'b0);
      send_beat(32'h00161514, 4'b0111, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
         $display("FAIL rstmid_ready: got %b want 0", in_ready);
         bad++;
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, out_keep, out_last} !== 6'b0) begin
         $display("FAIL rstmid_out: got v/k/l=%b want 000000", {out_valid, out_keep, out_last});
         bad++;
      end
      out_ready = 1'b1;
      obs_q.delete();
      step();
      send_beat(32'h5A6B7C8D, 4'hf, 1'b1);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 1) begin
         $display("FAIL rstmid_count: got %0d want 1", obs_q.size());
         bad++;
      end else begin
         total++;
         if ({obs_q[0].data, obs_q[0].keep, obs_q[0].last} !== {32'h5A6B7C8D, 4'hf, 1'b1}) begin
            $display("FAIL rstmid_beat: got %h/%h/%b want 5a6b7c8d/f/1",
                     obs_q[0].data, obs_q[0].keep, obs_q[0].last);
            bad++;
         end
      end
   endtask

   task automatic test_empty();
      obs_q.delete();
      send_beat(32'hFFFFFFFF, 4'b0000, 1'b0);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         $display("FAIL empty_nolast: out_valid got %b want 0", out_valid);
         bad++;
      end
      step();
      send_beat(32'hEEEEEEEE, 4'b0000, 1'b1);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 1) begin
         $display("FAIL empty_count: got %0d want 1", obs_q.size());
         bad++;
      end else begin
         total++;
         if ({obs_q[0].keep, obs_q[0].last} !== {4'h0, 1'b1}) begin
            $display("FAIL empty_beat: got keep %h last %b want 0/1", obs_q[0].keep, obs_q[0].last);
            bad++;
         end
      end
   endtask

   task automatic test_random();
      int nb;
      obs_q.delete();
      exp_q.delete();
      pend.delete();
      rand_rdy = 1'b1;
      for (int p = 0; p < 40; p++) begin
         nb = $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) begin
            logic [31:0] d;
            logic [3:0]  k;
            repeat ($urandom_range(0, 2)) step();
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            model_beat(d, k, b == nb - 1);
            send_beat(d, k, b == nb - 1);
         end
      end
      for (int t = 0; t < 2000 && obs_q.size() < exp_q.size(); t++) step();
      rand_rdy = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      repeat (5) step();
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
         bad++;
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if ({obs_q[i].keep, obs_q[i].last, obs_q[i].data & kmask(exp_q[i].keep)} !==
             {exp_q[i].keep, exp_q[i].last, exp_q[i].data & kmask(exp_q[i].keep)}) begin
            $display("FAIL rand_beat%0d: got %h/%h/%b want %h/%h/%b", i,
                     obs_q[i].data & kmask(exp_q[i].keep), obs_q[i].keep, obs_q[i].last,
                     exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            bad++;
         end
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      in_keep   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_dense();
      test_tail();
      test_backpressure();
      test_sparse();
      test_back_to_back();
      test_reset_mid();
      test_empty();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
